// File: rtl/adder_measure_ctrl_if.sv
// Wishbone slave bus bundle for the adder ring measurement controller.
interface adder_measure_ctrl_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/adder_measure_ctrl.sv
// Drives adder operands, gates the adder ring oscillator for a programmed
// window and counts its synchronized rising edges; Wishbone register front end.
module adder_measure_ctrl #(
    parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
    parameter int          SYNC_STAGES   = 2,
    parameter int          SETTLE_CYCLES = 4
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n_i,
    adder_measure_ctrl_if.slave  wb,
    input  logic                 ring_osc_i,
    output logic [31:0]          adder_a_o,
    output logic [31:0]          adder_b_o,
    output logic                 ring_en_o,
    output logic                 busy_o,
    output logic                 irq_o
);
    typedef enum logic [2:0] {IDLE, SETTLE, RUN, FLUSH, DONE} state_t;

    state_t                 state_q, state_d;
    logic [31:0]            tmr_q, tmr_d;
    logic [31:0]            window_q, window_d, opa_q, opa_d, opb_q, opb_d;
    logic [31:0]            count_q, count_d, cnt_q, cnt_d;
    logic                   done_q, done_d, ovf_q, ovf_d;
    logic                   ack_q, ack_d;
    logic [31:0]            dat_q, dat_d, rdata;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    logic       hit, acc, wr, start_wr, abort_wr, busy, rise;
    logic [2:0] idx;
    logic       unused_bits;

    assign unused_bits = ^{wb.wbs_sel_i, wb.wbs_adr_i[1:0]};

    assign hit      = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    assign acc      = hit & ~ack_q;
    assign wr       = acc & wb.wbs_we_i;
    assign idx      = wb.wbs_adr_i[4:2];
    assign start_wr = wr & (idx == 3'd0) & wb.wbs_dat_i[0] & ~wb.wbs_dat_i[1];
    assign abort_wr = wr & (idx == 3'd0) & wb.wbs_dat_i[1];
    assign busy     = (state_q != IDLE);
    assign rise     = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q  <= IDLE;
            tmr_q    <= '0;
            window_q <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            count_q  <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
            sync_q   <= '0;
            prev_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            window_q <= window_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            count_q  <= count_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            sync_q   <= sync_d;
            prev_q   <= prev_d;
        end
    end

    // Each phase loads tmr with (length-1) on entry and leaves when it hits 0.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        case (state_q)
            IDLE: if (start_wr && window_q != 32'd0) begin
                state_d = SETTLE;
                tmr_d   = 32'(SETTLE_CYCLES - 1);
            end
            SETTLE: if (tmr_q == 32'd0) begin
                state_d = RUN;
                tmr_d   = window_q - 32'd1;
            end else tmr_d = tmr_q - 32'd1;
            RUN: if (tmr_q == 32'd0) begin
                state_d = FLUSH;
                tmr_d   = 32'(SYNC_STAGES + 1);
            end else tmr_d = tmr_q - 32'd1;
            FLUSH: if (tmr_q == 32'd0) state_d = DONE;
                   else tmr_d = tmr_q - 32'd1;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_wr && busy) state_d = IDLE;
    end

    always_comb begin
        window_d = window_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        count_d  = count_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        ovf_d    = ovf_q;
        sync_d   = {sync_q[SYNC_STAGES-2:0], ring_osc_i};
        prev_d   = sync_q[SYNC_STAGES-1];
        if (wr && !busy) begin
            case (idx)
                3'd1:    window_d = wb.wbs_dat_i;
                3'd2:    opa_d    = wb.wbs_dat_i;
                3'd3:    opb_d    = wb.wbs_dat_i;
                default: ;
            endcase
        end
        if (state_q == IDLE && state_d == SETTLE) begin
            cnt_d  = '0;
            ovf_d  = 1'b0;
            done_d = 1'b0;
        end
        if (state_q == RUN && rise) begin
            if (cnt_q == 32'hFFFF_FFFF) ovf_d = 1'b1;
            else                        cnt_d = cnt_q + 32'd1;
        end
        if (state_q == DONE && !abort_wr) begin
            count_d = cnt_q;
            done_d  = 1'b1;
        end
    end

    always_comb begin
        case (idx)
            3'd1:    rdata = window_q;
            3'd2:    rdata = opa_q;
            3'd3:    rdata = opb_q;
            3'd4:    rdata = count_q;
            3'd5:    rdata = {29'b0, ovf_q, done_q, busy};
            default: rdata = '0;
        endcase
        ack_d = acc;
        dat_d = (acc && !wb.wbs_we_i) ? rdata : 32'd0;
    end

    always_comb begin
        ring_en_o = (state_q == RUN);
        busy_o    = busy;
        irq_o     = (state_q == DONE) && !abort_wr;
    end

    assign adder_a_o    = opa_q;
    assign adder_b_o    = opb_q;
    assign wb.wbs_ack_o = ack_q;
    assign wb.wbs_dat_o = dat_q;
endmodule

// File: tb/tb_adder_measure_ctrl.sv
// Directed bench for adder_measure_ctrl: register access, measurement,
// abort, busy write protection, saturation and asynchronous reset.
module tb_adder_measure_ctrl;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ring_osc = 1'b0;
    logic [31:0] adder_a, adder_b;
    logic        ring_en, busy, irq;

    int vectors = 0;
    int miscompares = 0;
    int irq_cnt = 0;
    int en_cnt = 0;

    adder_measure_ctrl_if wb ();

    adder_measure_ctrl dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wb         (wb.slave),
        .ring_osc_i (ring_osc),
        .adder_a_o  (adder_a),
        .adder_b_o  (adder_b),
        .ring_en_o  (ring_en),
        .busy_o     (busy),
        .irq_o      (irq)
    );

    initial forever #5 clk = ~clk;
    // Oscillator period = 10 clock periods.
    initial forever #50 ring_osc = ~ring_osc;

    always @(negedge clk) begin
        if (irq) irq_cnt++;
        if (ring_en) en_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           output logic [31:0] rdat);
        int n;
        @(posedge clk); #1;
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = we;
        wb.wbs_adr_i = adr;  wb.wbs_dat_i = wdat;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!wb.wbs_ack_o && n < 10);
        if (!wb.wbs_ack_o) check("ack_timeout", 32'd0, 32'd1);
        rdat = wb.wbs_dat_o;
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
    endtask

    task automatic wr(input logic [2:0] r, input logic [31:0] d);
        logic [31:0] dummy;
        wb_xfer(1'b1, BASE | {27'd0, r, 2'b00}, d, dummy);
    endtask

    task automatic rd(input logic [2:0] r, output logic [31:0] d);
        wb_xfer(1'b0, BASE | {27'd0, r, 2'b00}, 32'd0, d);
    endtask

    task automatic wait_en(input string tag);
        int n = 0;
        while (!ring_en && n < 50) begin @(posedge clk); #1; n++; end
        if (!ring_en) check(tag, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 500) begin @(posedge clk); #1; n++; end
        if (busy) check(tag, 32'd1, 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        int acks;
        wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0; wb.wbs_we_i = 0;
        wb.wbs_sel_i = 4'hF; wb.wbs_adr_i = 0; wb.wbs_dat_i = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {25'd0, wb.wbs_ack_o, ring_en, busy, irq, 3'd0}, 32'd0);
        check("rst_dat", wb.wbs_dat_o, 32'd0);
        check("rst_adder_a", adder_a, 32'd0);
        rst_n = 1'b1;

        rd(3'd1, d); check("window_rst", d, 32'd0);
        rd(3'd5, d); check("status_rst", d, 32'd0);

        // Non-hit access must never ack
        @(posedge clk); #1;
        wb.wbs_cyc_i = 1; wb.wbs_stb_i = 1; wb.wbs_we_i = 1;
        wb.wbs_adr_i = 32'h4000_0004; wb.wbs_dat_i = 32'hDEAD_BEEF;
        acks = 0;
        repeat (4) begin @(posedge clk); #1; if (wb.wbs_ack_o) acks++; end
        wb.wbs_cyc_i = 0; wb.wbs_stb_i = 0; wb.wbs_we_i = 0;
        check("nonhit_ack", acks, 0);
        rd(3'd1, d); check("nonhit_window", d, 32'd0);

        // Start with WINDOW == 0 is ignored
        wr(3'd0, 32'd1);
        repeat (3) @(posedge clk); #1;
        check("win0_busy", {31'd0, busy}, 32'd0);
        rd(3'd5, d); check("win0_status", d, 32'd0);

        // Register readback
        wr(3'd1, 32'd100); rd(3'd1, d); check("window_rb", d, 32'd100);
        wr(3'd2, 32'h0000_A5A5); wr(3'd3, 32'h0000_5A5A);
        check("adder_a", adder_a, 32'h0000_A5A5);
        check("adder_b", adder_b, 32'h0000_5A5A);
        rd(3'd0, d); check("ctrl_read0", d, 32'd0);
        wr(3'd6, 32'h1111_1111); rd(3'd6, d); check("reg6_read0", d, 32'd0);

        // Abort around RUN cycle 50
        irq_cnt = 0;
        wr(3'd0, 32'd1);
        wait_en("abort_wait_en");
        repeat (47) @(posedge clk);
        wr(3'd0, 32'd2);
        check("abort_ring_en", {31'd0, ring_en}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        rd(3'd4, d); check("abort_count", d, 32'd0);
        rd(3'd5, d); check("abort_status", d, 32'd0);
        check("abort_irq", irq_cnt, 0);

        // Start+abort together: abort wins
        wr(3'd0, 32'd3);
        repeat (2) @(posedge clk); #1;
        check("startabort_busy", {31'd0, busy}, 32'd0);

        // Full measurement, WINDOW=100, osc period 10 clk
        irq_cnt = 0; en_cnt = 0;
        wr(3'd0, 32'd1);
        check("run_busy", {31'd0, busy}, 32'd1);
        rd(3'd5, d); check("status_busy", d, 32'd1);
        wr(3'd2, 32'h0000_1234);
        check("busy_opa_ignored", adder_a, 32'h0000_A5A5);
        wait_idle("meas_wait_idle");
        repeat (2) @(posedge clk); #1;
        check("meas_en_cycles", en_cnt, 100);
        check("meas_irq", irq_cnt, 1);
        rd(3'd4, d); check("meas_count_range", {31'd0, d >= 32'd9 && d <= 32'd11}, 32'd1);
        rd(3'd5, d); check("meas_status", d, 32'd2);
        wr(3'd2, 32'h0000_1234);
        check("opa_after_done", adder_a, 32'h0000_1234);

        // Saturation: hold the edge counter at its maximum during the window
        wr(3'd0, 32'd1);
        wait_en("sat_wait_en");
        @(negedge clk);
        force dut.cnt_q = 32'hFFFF_FFFF;
        wait_idle("sat_wait_idle");
        release dut.cnt_q;
        rd(3'd4, d); check("sat_count", d, 32'hFFFF_FFFF);
        rd(3'd5, d); check("sat_status", d, 32'd6);

        // Asynchronous reset in RUN
        wr(3'd0, 32'd1);
        wait_en("rst_wait_en");
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst_ctrl", {28'd0, ring_en, busy, irq, wb.wbs_ack_o}, 32'd0);
        check("arst_adder_a", adder_a, 32'd0);
        check("arst_adder_b", adder_b, 32'd0);
        check("arst_dat", wb.wbs_dat_o, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
